// File: rtl/div_iter_if.sv
// div_iter_if: request/result bundle between the execute stage and div_iter.
//   master (execute): drives signed_div_in, opdata1_in, opdata2_in, start_in,
//                     annul_in; receives result_out, ready_out, busy_out,
//                     div_zero_out.
//   slave  (divider): the reverse directions.
interface div_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic               signed_div_in;
  logic [WIDTH-1:0]   opdata1_in;
  logic [WIDTH-1:0]   opdata2_in;
  logic               start_in;
  logic               annul_in;
  logic [2*WIDTH-1:0] result_out;
  logic               ready_out;
  logic               busy_out;
  logic               div_zero_out;

  modport master (
    output signed_div_in, opdata1_in, opdata2_in, start_in, annul_in,
    input  result_out, ready_out, busy_out, div_zero_out
  );

  modport slave (
    input  signed_div_in, opdata1_in, opdata2_in, start_in, annul_in,
    output result_out, ready_out, busy_out, div_zero_out
  );
endinterface

// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider, signed or unsigned.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : div_iter_if.slave -- operands/start/annul in; {rem, quo} result,
//          ready, busy and divide-by-zero flags out (all registered).
// One quotient bit per cycle on magnitudes; signs are applied on the last step.
module div_iter #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          EARLY_TERM = 1'b0
) (
  input logic       clk,
  input logic       rst,
  div_iter_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               early_q, early_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               dz_q, dz_d;

  // Operand magnitudes at latch time; most-negative stays as 2^(WIDTH-1) unsigned
  logic [WIDTH-1:0] abs1_c, abs2_c;
  assign abs1_c = (bus.signed_div_in && bus.opdata1_in[WIDTH-1]) ?
                  WIDTH'(-bus.opdata1_in) : bus.opdata1_in;
  assign abs2_c = (bus.signed_div_in && bus.opdata2_in[WIDTH-1]) ?
                  WIDTH'(-bus.opdata2_in) : bus.opdata2_in;

  // One restoring step; partial remainder < divisor, so the difference fits WIDTH bits
  logic [WIDTH:0]   shifted_c, diff_c;
  logic             fits_c;
  logic [WIDTH-1:0] step_rem_c, step_quo_c, fix_rem_c, fix_quo_c;
  assign shifted_c  = {rem_q, quo_q[WIDTH-1]};
  assign diff_c     = shifted_c - {1'b0, dvs_q};
  assign fits_c     = (shifted_c >= {1'b0, dvs_q});
  assign step_rem_c = fits_c ? diff_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
  assign step_quo_c = {quo_q[WIDTH-2:0], fits_c};
  assign fix_rem_c  = neg_rem_q ? WIDTH'(-step_rem_c) : step_rem_c;
  assign fix_quo_c  = neg_quo_q ? WIDTH'(-step_quo_c) : step_quo_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      early_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      early_q   <= early_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      dz_q      <= dz_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    early_d   = early_q;
    result_d  = result_q;
    ready_d   = ready_q;
    dz_d      = dz_q;

    case (state_q)
      IDLE: begin
        if (bus.start_in && !bus.annul_in) begin
          dvd_d     = bus.opdata1_in;
          dvs_d     = abs2_c;
          rem_d     = '0;
          quo_d     = abs1_c;
          cnt_d     = '0;
          neg_quo_d = bus.signed_div_in &
                      (bus.opdata1_in[WIDTH-1] ^ bus.opdata2_in[WIDTH-1]);
          neg_rem_d = bus.signed_div_in & bus.opdata1_in[WIDTH-1];
          early_d   = 1'b0;
          if (bus.opdata2_in == '0) begin
            state_d = DIVZERO;
          end else begin
            state_d = ON;
            if (EARLY_TERM && (abs1_c < abs2_c)) early_d = 1'b1;
          end
        end
      end

      DIVZERO: begin
        state_d  = END;
        result_d = '0;
        ready_d  = 1'b1;
        dz_d     = 1'b1;
      end

      ON: begin
        if (bus.annul_in) begin
          state_d  = IDLE;
          result_d = '0;
          ready_d  = 1'b0;
          rem_d    = '0;
          quo_d    = '0;
          cnt_d    = '0;
          early_d  = 1'b0;
        end else if (early_q) begin
          // |dividend| < |divisor|: quotient 0, remainder is the raw dividend
          state_d  = END;
          result_d = {dvd_q, WIDTH'(0)};
          ready_d  = 1'b1;
          early_d  = 1'b0;
        end else begin
          rem_d = step_rem_c;
          quo_d = step_quo_c;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = END;
            result_d = {fix_rem_c, fix_quo_c};
            ready_d  = 1'b1;
            cnt_d    = '0;
          end
        end
      end

      END: begin
        if (!bus.start_in) begin
          state_d  = IDLE;
          result_d = '0;
          ready_d  = 1'b0;
          dz_d     = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ON) || (state_d == DIVZERO);
  end

  assign bus.result_out   = result_q;
  assign bus.ready_out    = ready_q;
  assign bus.busy_out     = busy_q;
  assign bus.div_zero_out = dz_q;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed vectors for div_iter (WIDTH=32), run on two instances
// sharing the same stimulus: EARLY_TERM=0 (dut0) and EARLY_TERM=1 (dut1).
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  int          errors, checks;

  div_iter_if #(.WIDTH(32)) bus0 ();
  div_iter_if #(.WIDTH(32)) bus1 ();

  assign bus0.signed_div_in = signed_div;
  assign bus0.opdata1_in    = op1;
  assign bus0.opdata2_in    = op2;
  assign bus0.start_in      = start;
  assign bus0.annul_in      = annul;
  assign bus1.signed_div_in = signed_div;
  assign bus1.opdata1_in    = op1;
  assign bus1.opdata2_in    = op2;
  assign bus1.start_in      = start;
  assign bus1.annul_in      = annul;

  div_iter #(.WIDTH(32), .EARLY_TERM(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  div_iter #(.WIDTH(32), .EARLY_TERM(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation, hold start until dut0 is ready, then drop start
  task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res,
                        input int exp_lat, input int exp_lat_et, input logic exp_dz);
    int n, et_n, busy_n;
    logic [63:0] et_res;
    logic et_dz;
    @(negedge clk);
    signed_div = sd; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    @(posedge clk); #1;
    busy_n = bus0.busy_out ? 1 : 0;
    n = 0; et_n = 0; et_res = '0; et_dz = 1'b0;
    while (!bus0.ready_out && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus1.ready_out && et_n == 0) begin
        et_n = n; et_res = bus1.result_out; et_dz = bus1.div_zero_out;
      end
      if (!bus0.ready_out && bus0.busy_out) busy_n++;
    end
    check({tag, "/lat"}, 64'(n), 64'(exp_lat));
    check({tag, "/result"}, bus0.result_out, exp_res);
    check({tag, "/dz"}, 64'(bus0.div_zero_out), 64'(exp_dz));
    check({tag, "/busy_cycles"}, 64'(busy_n), 64'(exp_lat));
    check({tag, "/busy_at_ready"}, 64'(bus0.busy_out), 64'd0);
    check({tag, "/et_lat"}, 64'(et_n), 64'(exp_lat_et));
    check({tag, "/et_result"}, et_res, exp_res);
    check({tag, "/et_dz"}, 64'(et_dz), 64'(exp_dz));
    @(posedge clk); #1;
    check({tag, "/hold_ready"}, 64'(bus0.ready_out), 64'd1);
    check({tag, "/hold_result"}, bus0.result_out, exp_res);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "/drop_ready"}, 64'(bus0.ready_out), 64'd0);
    check({tag, "/drop_result"}, bus0.result_out, 64'd0);
    check({tag, "/drop_dz"}, 64'(bus0.div_zero_out), 64'd0);
  endtask

  initial begin
    int rose;
    errors = 0; checks = 0;
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    #3;
    check("reset/result", bus0.result_out, 64'd0);
    check("reset/flags", {61'd0, bus0.ready_out, bus0.busy_out, bus0.div_zero_out}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("u100_7",   1'b0, 32'd100,       32'd7,          {32'd2, 32'd14},                 32, 32, 1'b0);
    run_op("s-7_2",    1'b1, 32'hFFFFFFF9,  32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    32, 32, 1'b0);
    run_op("smin_-1",  1'b1, 32'h80000000,  32'hFFFFFFFF,   {32'd0, 32'h80000000},           32, 32, 1'b0);
    run_op("s7_-2",    1'b1, 32'd7,         32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           32, 32, 1'b0);
    run_op("uFFF9_2",  1'b0, 32'hFFFFFFF9,  32'd2,          {32'd1, 32'h7FFFFFFC},           32, 32, 1'b0);
    run_op("umax_1",   1'b0, 32'hFFFFFFFF,  32'd1,          {32'd0, 32'hFFFFFFFF},           32, 32, 1'b0);
    run_op("u5_0",     1'b0, 32'd5,         32'd0,          64'd0,                           1,  1,  1'b1);
    run_op("s-3_10",   1'b1, 32'hFFFFFFFD,  32'd10,         {32'hFFFFFFFD, 32'd0},           32, 1,  1'b0);

    // start together with annul in IDLE is ignored
    @(negedge clk);
    op1 = 32'd5; op2 = 32'd1; signed_div = 1'b0; start = 1'b1; annul = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ign/busy", 64'(bus0.busy_out), 64'd0);
    check("ign/ready", 64'(bus0.ready_out), 64'd0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;

    // annul at cycle 10 of ON
    @(negedge clk);
    op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b0; annul = 1'b1;
    @(posedge clk); #1;
    check("annul/busy", 64'(bus0.busy_out), 64'd0);
    check("annul/ready", 64'(bus0.ready_out), 64'd0);
    check("annul/result", bus0.result_out, 64'd0);
    check("annul/et_busy", 64'(bus1.busy_out), 64'd0);
    @(negedge clk);
    annul = 1'b0;
    rose = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus0.ready_out) rose = 1;
    end
    check("annul/never_ready", 64'(rose), 64'd0);
    run_op("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, 32, 1'b0);

    // asynchronous reset mid-operation
    @(negedge clk);
    op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (16) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid/busy", 64'(bus0.busy_out), 64'd0);
    check("rst_mid/ready", 64'(bus0.ready_out), 64'd0);
    check("rst_mid/result", bus0.result_out, 64'd0);
    check("rst_mid/et_busy", 64'(bus1.busy_out), 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op("u64_8", 1'b0, 32'd64, 32'd8, {32'd0, 32'd8}, 32, 32, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Parametrised multi-cycle radix-2 restoring divider for the execute stage. It is the successor to the fixed 32-bit divider.
- Adds a generic operand width, an explicit busy flag and a divide-by-zero flag.
- Adds an optional early-out when |dividend| < |divisor|.
- Result is packed {remainder, quotient}, so it feeds the HI/LO write path directly (HI=remainder, LO=quotient).

Parameters:
WIDTH, 32, operand width in bits; must be >= 2. Iteration counter width is derived internally (clog2(WIDTH)+1).
EARLY_TERM, 0, 1 = finish in one iteration cycle when |dividend| < |divisor|; 0 = always run WIDTH iterations.

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous, active-low reset
signed_div_in  input  1  1 = signed (two's complement) division, 0 = unsigned
opdata1_in  input  WIDTH  dividend
opdata2_in  input  WIDTH  divisor
start_in  input  1  request; held high by execute until ready_out is seen
annul_in  input  1  abort current operation
result_out  output  2*WIDTH  {remainder, quotient}
ready_out  output  1  result valid (registered)
busy_out  output  1  high while in DIVZERO or ON
div_zero_out  output  1  high with ready_out when divisor was zero

Behaviour:
- Reset (rst low, any time, including mid-operation): state=IDLE; result_out, ready_out, busy_out, div_zero_out all 0; counter and working registers 0. Effect is immediate, with no clock edge needed.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - start_in=1 and annul_in=0 at an edge (E0) latches operands and signed_div_in, then:
    - divisor==0: go to DIVZERO.
    - EARLY_TERM=1 and |dividend| < |divisor|: go to ON with early flag set.
    - Otherwise: go to ON with counter=0.
  - start_in=1 and annul_in=1 together: request ignored, stay IDLE.
- Signed mode: absolute values are taken at latch time. The most-negative operand stays as magnitude 2^(WIDTH-1), held unsigned.
- ON:
  - Each edge performs one restoring step: shift the partial remainder left 1, subtract the divisor magnitude, keep the result if non-negative and shift in quotient bit 1, else shift in 0.
  - The WIDTH-th step (counter == WIDTH-1) happens at edge E_WIDTH. On that edge: state goes to END; sign-correct and register result_out; ready_out=1. Latency is WIDTH cycles from E0 to ready_out visible.
  - Early flag set: at E1 go to END with quotient=0 and remainder=original dividend (signed value preserved).
  - annul_in=1 at any ON edge: go to IDLE; ready_out stays 0; result_out=0; the partial result is discarded.
  - Operand input changes during ON are ignored.
- DIVZERO: next edge (E1) goes to END with result_out=0, div_zero_out=1, ready_out=1.
- END:
  - Outputs hold while start_in=1.
  - First edge with start_in=0: go to IDLE, clearing ready_out, div_zero_out and result_out to 0.
  - annul_in in END has no effect beyond this.
  - A new operation needs at least one IDLE edge: start must drop before it is re-asserted.
- Sign rules (signed mode, MIPS semantics):
  - Quotient is negated when operand signs differ.
  - Remainder takes the dividend's sign.
  - Most-negative / -1 gives quotient = most-negative (wraps) and remainder 0. No overflow flag.
- busy_out = (state==ON or state==DIVZERO). It is a registered state decode and is never high together with ready_out.
- All outputs are driven from registers; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=32, unsigned, 100/7, start held high -> ready_out rises 32 cycles after the sampling edge; result_out={32'd2, 32'd14}; busy_out high for exactly 32 cycles.
- Signed, 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- 5/0 -> ready_out and div_zero_out high 1 cycle after E0; result_out=0. Dropping start_in -> all three outputs 0 on the next edge.
- Start 1000/3, assert annul_in for one cycle at cycle 10 of ON -> state IDLE, ready_out never rises. A fresh start with 9/3 then completes with {0, 3} after 32 cycles.
- EARLY_TERM=1, signed 0xFFFFFFFD (-3) / 10 -> ready_out 1 cycle after E0; result_out={0xFFFFFFFD, 0}. EARLY_TERM=0, same operands -> 32 cycles, same result.
- Pull rst low at cycle 16 of ON, asynchronously between edges -> all outputs 0 immediately. After release, 64/8 completes in 32 cycles with {0, 8}.
